fadd_pipe: RTL and testbench

- Single-precision IEEE-754 floating-point adder with one registered output stage.
- Computes y = x1 + x2 with round-to-nearest-even and full subnormal support.
- Results are bit-exact with a standard binary32 (shortreal) addition.
- Datapath primitive used by FP arithmetic units; accepts one operand pair per clock.

---
 rtl/fadd_pipe.sv | 128 ++++++++++++
 tb/tb_fadd_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fadd_pipe.sv
// rtl/fadd_pipe.sv - binary32 adder, round-to-nearest-even, one registered output stage
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset (clears y and ovf)
//   x1    operand A, binary32
//   x2    operand B, binary32
//   y     registered sum x1 + x2, binary32
//   ovf   registered flag: finite operands overflowed to Inf
module fadd_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    logic [31:0] a, b;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea, eb, d, lz, limit, shl;
    logic [4:0]  ds;
    logic [23:0] ma, mb;
    logic [49:0] wide;
    logic [26:0] la, sm, diff, m;
    logic [27:0] sum;
    logic        eff_sub, up;
    logic [9:0]  e10, efield;
    logic [32:0] r;
    logic [31:0] y_n;
    logic        ovf_n;

    always_comb begin
        // Larger magnitude goes first; the raw 31-bit magnitude field orders
        // correctly because exponent sits above fraction.
        if (x2[30:0] > x1[30:0]) begin
            a = x2;
            b = x1;
        end else begin
            a = x1;
            b = x2;
        end

        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

        // Subnormals use effective exponent 1 with hidden bit 0.
        ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma = {a[30:23] != 8'd0, a[22:0]};
        mb = {b[30:23] != 8'd0, b[22:0]};

        // Align: 24-bit significand + guard + round + sticky. Gaps beyond 26
        // leave only the sticky bit, so the shift amount is clamped.
        d    = ea - eb;
        ds   = (d > 8'd26) ? 5'd26 : d[4:0];
        wide = {mb, 26'd0} >> ds;
        sm   = {wide[49:24], |wide[23:0]};
        la   = {ma, 3'b000};

        eff_sub = a[31] ^ b[31];
        sum     = {1'b0, la} + {1'b0, sm};
        diff    = la - sm;

        lz = 8'd27;
        for (int i = 0; i < 27; i++) begin
            if (diff[i]) lz = 8'(26 - i);
        end
        // Normalisation stops at exponent 1; anything left unnormalised is subnormal.
        limit = ea - 8'd1;
        shl   = (lz > limit) ? limit : lz;

        if (eff_sub) begin
            m   = diff << shl;
            e10 = {2'b00, ea} - {2'b00, shl};
        end else if (sum[27]) begin
            m   = {sum[27:2], sum[1] | sum[0]};
            e10 = {2'b00, ea} + 10'd1;
        end else begin
            m   = sum[26:0];
            e10 = {2'b00, ea};
        end

        efield = m[26] ? e10 : 10'd0;

        // Ties to even. Adding the round bit to {exponent, fraction} lets a
        // mantissa carry bump the exponent, including subnormal -> 2^-126.
        up = m[2] & (m[1] | m[0] | m[3]);
        r  = {efield, m[25:3]} + 33'(up);

        ovf_n = 1'b0;
        if (r[32:23] >= 10'd255) begin
            y_n   = {a[31], 8'hFF, 23'd0};
            ovf_n = 1'b1;
        end else begin
            y_n = {a[31], r[30:0]};
        end

        // Exact cancellation of opposite signs is +0.
        if (eff_sub && (diff == 27'd0)) begin
            y_n = 32'd0;
        end

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            y_n   = 32'h7FC00000;
            ovf_n = 1'b0;
        end else if (a_inf) begin
            y_n   = a;
            ovf_n = 1'b0;
        end else if (b_inf) begin
            y_n   = b;
            ovf_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y   <= 32'd0;
            ovf <= 1'b0;
        end else begin
            y   <= y_n;
            ovf <= ovf_n;
        end
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb/tb_fadd_pipe.sv - self-checking bench for fadd_pipe
module tb_fadd_pipe;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x1   = 32'd0;
    logic [31:0] x2   = 32'd0;
    logic [31:0] y;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    logic [32:0] in_lit    = 33'd0;
    logic        in_lit_v  = 1'b0;
    logic [32:0] cap_exp   = 33'd0;
    logic [32:0] cap_lit   = 33'd0;
    logic        cap_lit_v = 1'b0;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_a     = 32'd0;
    logic [31:0] cap_b     = 32'd0;

    always #5 clk = ~clk;

    fadd_pipe dut (
        .clk (clk),
        .rstn(rstn),
        .x1  (x1),
        .x2  (x2),
        .y   (y),
        .ovf (ovf)
    );

    // Exact sum in units of 2^-149, then rounded back to binary32.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [300:0] va, vb, mag, q, rem, half;
        logic         sgn, a_nan, b_nan, a_inf, b_inf;
        int           p, sh, fld;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return {1'b0, 32'h7FC00000};
        if (a_inf) return {1'b0, a};
        if (b_inf) return {1'b0, b};
        if (a[30:23] == 0) va = 301'(a[22:0]);
        else               va = 301'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1);
        if (b[30:23] == 0) vb = 301'(b[22:0]);
        else               vb = 301'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1);
        if (a[31] == b[31]) begin
            mag = va + vb;
            sgn = a[31];
        end else if (va >= vb) begin
            mag = va - vb;
            sgn = a[31];
        end else begin
            mag = vb - va;
            sgn = b[31];
        end
        if (mag == 0) return {1'b0, (a[31] & b[31]), 31'd0};
        p = -1;
        for (int i = 300; i >= 0; i--) begin
            if (mag[i] && p < 0) p = i;
        end
        if (p <= 23) return {1'b0, sgn, 7'd0, mag[23], mag[22:0]};
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 301'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (301'(1) << 24)) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        fld = sh + 1;
        if (fld >= 255) return {1'b1, sgn, 8'hFF, 23'd0};
        return {1'b0, sgn, 8'(fld), q[22:0]};
    endfunction

    always @(posedge clk) begin
        if (rstn) begin
            cap_exp   = model(x1, x2);
            cap_lit   = in_lit;
            cap_lit_v = in_lit_v;
            cap_valid = 1'b1;
            cap_a     = x1;
            cap_b     = x2;
        end else begin
            cap_valid = 1'b0;
            cap_lit_v = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [32:0] want;
        want = (cap_valid && rstn) ? cap_exp : 33'd0;
        checks++;
        if ({ovf, y} !== want) begin
            failures++;
            $display("FAIL model a=%h b=%h got y=%h ovf=%b want y=%h ovf=%b",
                     cap_a, cap_b, y, ovf, want[31:0], want[32]);
        end
        if (cap_valid && rstn && cap_lit_v) begin
            checks++;
            if ({ovf, y} !== cap_lit) begin
                failures++;
                $display("FAIL literal a=%h b=%h got y=%h ovf=%b want y=%h ovf=%b",
                         cap_a, cap_b, y, ovf, cap_lit[31:0], cap_lit[32]);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic lv, input logic [32:0] lit);
        @(posedge clk);
        #2;
        x1       = a;
        x2       = b;
        in_lit_v = lv;
        in_lit   = lit;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] r;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{32'h80DFFFFF, 32'hDEFFFFFF, 33'h0DEFFFFFF});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 33'h040000000});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 33'h000000000});
        vecs.push_back('{32'h80000000, 32'h80000000, 33'h080000000});
        vecs.push_back('{32'h00000000, 32'h80000000, 33'h000000000});
        vecs.push_back('{32'h4B800000, 32'h3F800000, 33'h04B800000});
        vecs.push_back('{32'h4B800001, 32'h3F800000, 33'h04B800002});
        vecs.push_back('{32'h00000001, 32'h00000001, 33'h000000002});
        vecs.push_back('{32'h00800000, 32'h80000001, 33'h0007FFFFF});
        vecs.push_back('{32'h007FFFFF, 32'h00000001, 33'h000800000});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 33'h17F800000});
        vecs.push_back('{32'hFF7FFFFF, 32'hFF7FFFFF, 33'h1FF800000});
        vecs.push_back('{32'h7F800000, 32'hFF800000, 33'h07FC00000});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 33'h07FC00000});
        vecs.push_back('{32'hFF800000, 32'h3F800000, 33'h0FF800000});
        vecs.push_back('{32'hFF800000, 32'hFF800000, 33'h0FF800000});
        vecs.push_back('{32'h40400000, 32'hBF800000, 33'h040000000});
        vecs.push_back('{32'h3F800001, 32'hBF800000, 33'h034000000});

        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;

        foreach (vecs[i]) drive(vecs[i].a, vecs[i].b, 1'b1, vecs[i].r);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = {~ra[31], ra[30:0]} ^ 32'($urandom_range(0, 255));
            if (i % 3 == 2) rb = {rb[31], ra[30:23] - 8'($urandom_range(0, 30)), rb[22:0]};
            drive(ra, rb, 1'b0, 33'd0);
        end

        // Reset between edges: output clears before the next edge and stays
        // clear until the first edge after release.
        drive(32'h3F800000, 32'h3F800000, 1'b1, 33'h040000000);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        x1   = 32'h40000000;
        x2   = 32'h40000000;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        in_lit_v = 1'b1;
        in_lit   = 33'h040800000;
        drive(32'h4B800001, 32'h3F800000, 1'b1, 33'h04B800002);
        drive(32'h00000001, 32'h00000001, 1'b1, 33'h000000002);

        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
